// File: rtl/pwm_gen.sv
// pwm_gen: shadow-registered PWM generator with a two-state IDLE/RUN FSM.
//
// Period and pulse are sampled into shadow registers only at a load point:
// the IDLE->RUN transition or a period wrap. This means a new setting never
// truncates or distorts the period that is already running. Dropping en
// lets the current period finish and then returns the block to IDLE.
//
// Ports
//   sys_clk     : system clock; all state changes happen on its rising edge
//   sys_rst     : asynchronous, active-high reset
//   en          : run request (1 = generate PWM, 0 = stop at end of period)
//   period      : PWM period in sys_clk cycles; values below 2 are refused
//   pulse       : high time per period in sys_clk cycles (compare value)
//   pwm_out     : registered PWM waveform, one cycle behind cnt
//   cycle_done  : combinational strobe during the last count of each period
//   busy        : high while the FSM is in RUN
module pwm_gen #(
   parameter int CNT_W = 26
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] pulse,
   output logic             pwm_out,
   output logic             cycle_done,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] period_sh;
   logic [CNT_W-1:0] period_sh_next;
   logic [CNT_W-1:0] pulse_sh;
   logic [CNT_W-1:0] pulse_sh_next;
   logic             pwm_next;
   logic             period_ok;
   logic             last_cnt;

   // A period of 0 or 1 cannot be counted (period_sh - 1 would underflow
   // or leave no room for a wrap), so such values are never loaded.
   assign period_ok = (period >= TWO);

   // period_sh is always >= 2 while in RUN, so the subtraction is safe there.
   // In IDLE the result is ignored.
   assign last_cnt  = (cnt == (period_sh - ONE));

   assign busy       = (state == RUN);
   assign cycle_done = (state == RUN) && last_cnt;

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      period_sh_next = period_sh;
      pulse_sh_next  = pulse_sh;
      pwm_next       = 1'b0;

      case (state)
         IDLE: begin
            cnt_next = '0;
            if (en && period_ok) begin
               state_next     = RUN;
               period_sh_next = period;
               pulse_sh_next  = pulse;
            end
         end

         RUN: begin
            // Unsigned compare saturates naturally: pulse_sh = 0 gives a
            // constant low, pulse_sh >= period_sh gives a constant high.
            pwm_next = (cnt < pulse_sh);
            if (last_cnt) begin
               cnt_next = '0;
               if (!en || !period_ok) begin
                  state_next = IDLE;
                  // Leaving RUN: suppress the last compare result so the
                  // first IDLE cycle is already low (no trailing high cycle
                  // when pulse_sh >= period_sh).
                  pwm_next   = 1'b0;
               end else begin
                  period_sh_next = period;
                  pulse_sh_next  = pulse;
               end
            end else begin
               cnt_next = cnt + ONE;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         period_sh <= '0;
         pulse_sh  <= '0;
         pwm_out   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         period_sh <= period_sh_next;
         pulse_sh  <= pulse_sh_next;
         pwm_out   <= pwm_next;
      end
   end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: randomized and directed bench for pwm_gen.
// A behavioural model tracks position within the current period and the
// latched settings; every cycle the DUT outputs are compared against it.
// A second, 8-bit instance exercises a full-scale counter wrap.
module tb_pwm_gen;

   localparam int W = 26;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          en;
   logic [W-1:0]  period;
   logic [W-1:0]  pulse;
   logic          pwm_out;
   logic          cycle_done;
   logic          busy;

   logic          en8;
   logic [7:0]    period8;
   logic [7:0]    pulse8;
   logic          pwm8;
   logic          cd8;
   logic          busy8;

   int n_tests = 0;
   int n_fail  = 0;

   pwm_gen #(.CNT_W(W)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .en         (en),
      .period     (period),
      .pulse      (pulse),
      .pwm_out    (pwm_out),
      .cycle_done (cycle_done),
      .busy       (busy)
   );

   pwm_gen #(.CNT_W(8)) dut8 (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .en         (en8),
      .period     (period8),
      .pulse      (pulse8),
      .pwm_out    (pwm8),
      .cycle_done (cd8),
      .busy       (busy8)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural reference ----------------
   // running : a period is in progress
   // pos     : position inside the current period (0 .. per-1)
   // per/hi  : settings latched at the last load point
   // level   : expected pwm_out, i.e. "was the previous cycle inside the
   //           high window of a period that is not ending in a stop"
   bit     m_running;
   longint m_pos, m_per, m_hi;
   bit     m_level;

   function automatic void model_reset();
      m_running = 1'b0;
      m_pos     = 0;
      m_per     = 0;
      m_hi      = 0;
      m_level   = 1'b0;
   endfunction

   function automatic void model_clock(input bit run_req, input longint p_in, input longint h_in);
      bit at_end;
      bit stopping;
      if (!m_running) begin
         m_level = 1'b0;
         if (run_req && p_in >= 2) begin
            m_running = 1'b1;
            m_per     = p_in;
            m_hi      = h_in;
            m_pos     = 0;
         end
      end else begin
         at_end   = (m_pos + 1 == m_per);
         stopping = at_end && (!run_req || p_in < 2);
         m_level  = (m_pos < m_hi) && !stopping;
         if (!at_end) begin
            m_pos = m_pos + 1;
         end else if (stopping) begin
            m_running = 1'b0;
            m_pos     = 0;
         end else begin
            m_per = p_in;
            m_hi  = h_in;
            m_pos = 0;
         end
      end
   endfunction

   function automatic bit model_done();
      return m_running && (m_pos + 1 == m_per);
   endfunction

   // One clock: update the model from the inputs held across the edge,
   // then compare all outputs at the following falling edge.
   task automatic cycle(input string tag);
      @(posedge sys_clk);
      if (!sys_rst) model_clock(en, longint'(period), longint'(pulse));
      @(negedge sys_clk);
      check_val({tag, ".pwm"},  {31'd0, pwm_out},    {31'd0, m_level});
      check_val({tag, ".busy"}, {31'd0, busy},       {31'd0, m_running});
      check_val({tag, ".done"}, {31'd0, cycle_done}, {31'd0, model_done()});
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 70; i++) begin
         if (!busy) break;
         cycle(tag);
      end
      check_val({tag, ".idle_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic async_reset_check(input string tag);
      sys_rst = 1'b1;
      model_reset();
      #1;
      check_val({tag, ".rst_pwm"},  {31'd0, pwm_out},    32'd0);
      check_val({tag, ".rst_busy"}, {31'd0, busy},       32'd0);
      check_val({tag, ".rst_done"}, {31'd0, cycle_done}, 32'd0);
   endtask

   int highs, dones, busies;

   initial begin
      sys_rst = 1'b1;
      en      = 1'b0;
      period  = '0;
      pulse   = '0;
      en8     = 1'b0;
      period8 = '0;
      pulse8  = '0;
      model_reset();
      #12;
      check_val("reset.pwm",  {31'd0, pwm_out},    32'd0);
      check_val("reset.busy", {31'd0, busy},       32'd0);
      check_val("reset.done", {31'd0, cycle_done}, 32'd0);
      cycle("reset");
      cycle("reset");
      sys_rst = 1'b0;

      // Basic run: period 10, pulse 2
      en = 1'b1; period = W'(10); pulse = W'(2);
      cycle("basic_load");
      highs = 0; dones = 0;
      for (int i = 0; i < 30; i++) begin
         cycle("basic");
         highs += int'(pwm_out);
         dones += int'(cycle_done);
      end
      check_val("basic.high_count", highs, 6);
      check_val("basic.done_count", dones, 3);

      // Shadow update mid-period: the running 10-cycle period is untouched
      for (int i = 0; i < 3; i++) cycle("shadow_pre");
      period = W'(20); pulse = W'(5);
      dones = 0;
      for (int i = 0; i < 7; i++) begin
         cycle("shadow_old");
         dones += int'(cycle_done);
      end
      check_val("shadow.old_done_count", dones, 1);
      highs = 0; dones = 0;
      for (int i = 0; i < 20; i++) begin
         cycle("shadow_new");
         highs += int'(pwm_out);
         dones += int'(cycle_done);
      end
      check_val("shadow.new_high_count", highs, 5);
      check_val("shadow.new_done_count", dones, 1);

      // Graceful stop at cnt=3 of a 10-cycle period
      en = 1'b0;
      wait_idle("stop_prep");
      en = 1'b1; period = W'(10); pulse = W'(2);
      cycle("stop_load");
      for (int i = 0; i < 3; i++) cycle("stop_run");
      en = 1'b0;
      for (int i = 0; i < 6; i++) cycle("stop_finish");
      check_val("stop.last_done", {31'd0, cycle_done}, 32'd1);
      highs = 0; busies = 0;
      for (int i = 0; i < 12; i++) begin
         cycle("stop_after");
         highs  += int'(pwm_out);
         busies += int'(busy);
      end
      check_val("stop.after_high", highs, 0);
      check_val("stop.after_busy", busies, 0);

      // Boundary: pulse = 0
      en = 1'b1; period = W'(10); pulse = W'(0);
      highs = 0;
      for (int i = 0; i < 25; i++) begin
         cycle("pulse0");
         highs += int'(pwm_out);
      end
      check_val("pulse0.high_count", highs, 0);
      en = 1'b0;
      wait_idle("pulse0_stop");
      cycle("pulse0_idle");

      // Boundary: pulse = period = 10, constant high after latency
      en = 1'b1; period = W'(10); pulse = W'(10);
      cycle("full_load");
      highs = 0;
      for (int i = 0; i < 24; i++) begin
         cycle("full");
         highs += int'(pwm_out);
      end
      check_val("full.high_count", highs, 24);
      en = 1'b0;
      wait_idle("full_stop");
      cycle("full_idle");
      check_val("full.stop_low", {31'd0, pwm_out}, 32'd0);

      // Boundary: period = 1 never starts
      en = 1'b1; period = W'(1); pulse = W'(1);
      busies = 0;
      for (int i = 0; i < 10; i++) begin
         cycle("period1");
         busies += int'(busy);
      end
      check_val("period1.busy_count", busies, 0);

      // Asynchronous reset while pwm_out is high
      period = W'(10); pulse = W'(2);
      for (int i = 0; i < 20; i++) begin
         cycle("arst_run");
         if (pwm_out) break;
      end
      check_val("arst.reached_high", {31'd0, pwm_out}, 32'd1);
      #2;
      async_reset_check("arst");
      cycle("arst_hold");
      sys_rst = 1'b0;
      cycle("arst_load");
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         cycle("arst_fresh");
         highs += int'(pwm_out);
      end
      check_val("arst.fresh_high", highs, 2);

      // Full-scale wrap on the 8-bit instance: period 2^8-1, pulse 2^7
      en = 1'b0;
      wait_idle("w8_prep");
      en8 = 1'b1; period8 = 8'd255; pulse8 = 8'd128;
      cycle("w8_load");
      highs = 0; dones = 0;
      for (int i = 0; i < 510; i++) begin
         cycle("w8");
         highs += int'(pwm8);
         dones += int'(cd8);
         if (i == 253) check_val("w8.wrap_done", {31'd0, cd8}, 32'd1);
      end
      check_val("w8.high_count", highs, 256);
      check_val("w8.done_count", dones, 2);
      check_val("w8.busy", {31'd0, busy8}, 32'd1);
      en8 = 1'b0;

      // Sampled full-width run: period 2^26-1, pulse 2^25 (aborted by reset)
      en = 1'b1; period = W'((1 << W) - 1); pulse = W'(1 << (W - 1));
      cycle("wmax_load");
      highs = 0;
      for (int i = 0; i < 200; i++) begin
         cycle("wmax");
         highs += int'(pwm_out);
      end
      check_val("wmax.high_count", highs, 200);
      #2;
      async_reset_check("wmax_abort");
      cycle("wmax_hold");
      sys_rst = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            en     = ($urandom_range(0, 3) != 0);
            period = W'($urandom_range(0, 16));
            if ($urandom_range(0, 9) == 0) pulse = W'(1 << (W - 1));
            else pulse = W'($urandom_range(0, 18));
         end
         if ($urandom_range(0, 499) == 0) begin
            #2;
            async_reset_check("rand_rst");
            cycle("rand_rst_hold");
            sys_rst = 1'b0;
         end else begin
            cycle("rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001: Parameter CNT_W, default 26, width of the period, pulse and counter paths.
REQ-002: sys_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003: sys_rst  input  1  asynchronous, active-high reset.
REQ-004: en  input  1  run request; 1 = generate PWM, 0 = stop at the end of the current period.
REQ-005: period  input  CNT_W  PWM period in sys_clk cycles.
REQ-006: pulse  input  CNT_W  high time per period in sys_clk cycles (compare value).
REQ-007: pwm_out  output  1  registered PWM waveform driving the beeper.
REQ-008: cycle_done  output  1  one-cycle strobe on the last count of each period.
REQ-009: busy  output  1  high while in RUN.

Function
REQ-010: The FSM SHALL have exactly two states, IDLE and RUN.
REQ-011: Shadow registers period_sh and pulse_sh SHALL be the only values used for counting and comparison.
- Inputs may change at any time.
- Changes take effect only at a load point: the IDLE->RUN transition or a period wrap.
REQ-012: In IDLE, cnt SHALL be held at 0.
REQ-013: In IDLE, when en=1 and period>=2, the block SHALL, on the same edge:
- latch period_sh<=period and pulse_sh<=pulse;
- set cnt<=0;
- enter RUN.
REQ-014: In IDLE with period<2, the block SHALL remain in IDLE regardless of en.
REQ-015: In RUN, cnt SHALL increment by 1 per cycle until cnt==period_sh-1.
REQ-016: When cnt==period_sh-1 in RUN (the wrap cycle), on the next edge:
- cnt<=0;
- period_sh and pulse_sh SHALL reload from the inputs.
REQ-017: cycle_done SHALL be 1 combinationally during the wrap cycle only; it is 0 in all other cycles.
REQ-018: At the wrap edge, if en=0 or the input period<2, the FSM SHALL go to IDLE instead of reloading.
REQ-019: Deasserting en mid-period SHALL NOT truncate the current period.
REQ-020: pwm_out SHALL be registered: pwm_out <= (state==RUN) && (cnt < pulse_sh), evaluated on the pre-edge state, cnt and pulse_sh values.
- This gives a fixed 1-cycle latency from cnt to pwm_out.
REQ-021: pulse_sh=0 SHALL give constant pwm_out=0 while running.
REQ-022: pulse_sh>=period_sh SHALL give constant pwm_out=1 while running; no clamping arithmetic is required, because the compare naturally saturates.
REQ-023: busy SHALL equal (state==RUN).
REQ-024: All comparisons SHALL be unsigned at CNT_W bits.
REQ-025: period_sh-1 SHALL never underflow, because RUN is only entered or kept with period_sh>=2.
REQ-026: In the cycle after the FSM returns to IDLE, pwm_out SHALL be 0 (glitch-free stop).

Reset
REQ-027: Asserting sys_rst SHALL immediately, with no clock required, force:
- state=IDLE;
- cnt=0, period_sh=0, pulse_sh=0;
- pwm_out=0, cycle_done=0, busy=0.
REQ-028: Reset asserted mid-period SHALL abort the period with no further pwm_out high.
REQ-029: After reset release, the block SHALL behave as IDLE per REQ-013/014 from the first clock edge.

Verification
REQ-030: Basic run: period=10, pulse=2, en=1 held.
- pwm_out is 1 for exactly 2 of every 10 cycles.
- cycle_done fires every 10 cycles.
- busy=1 from the first RUN cycle.
REQ-031: Shadow update: change to period=20, pulse=5 mid-period.
- The current 10-cycle period completes unchanged.
- The next period is 20 cycles with 5 high.
- Only one cycle_done occurs at the 10-cycle boundary.
REQ-032: Graceful stop: drop en at cnt=3 of period=10.
- The period finishes: cycle_done at cnt=9.
- busy and pwm_out are 0 from the following cycle.
- No further pulses occur.
REQ-033: Boundary values: run three separate cases.
- pulse=0: pwm_out stays 0.
- pulse=10, period=10: pwm_out stays 1 after the first latency cycle.
- period=1 with en=1: block stays IDLE, busy=0.
REQ-034: Async reset: assert sys_rst between clock edges while pwm_out=1.
- pwm_out, busy, cycle_done and cnt go 0 without a clock edge.
- After release with en=1, period=10, pulse=2, a fresh period starts.
REQ-035: Maximum width: period=2^26-1, pulse=2^25.
- cnt reaches 2^26-2 then wraps to 0 with no overflow.
- pwm_out is high for exactly 2^25 cycles (a sampled check is acceptable).
